regfile_nr_w: RTL and testbench

Parametrised multi-port register file for the datapath: `NREGS` registers of `WIDTH` bits, one synchronous write port and `NRD` independent combinational read ports. Each read port selects its register through a binary 2:1 mux tree, generalised from the fixed 32×64 read mux. The highest-indexed register can be hardwired to zero (XZR). An optional write-to-read bypass lets decode read a value that writeback is committing in the same cycle.

---
 rtl/regfile_nr_w.sv | 95 +++++++++
 tb/tb_regfile_nr_w.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_nr_w.sv
// regfile_nr_w: NREGS x WIDTH register file with one synchronous write port and NRD
// combinational read ports, each read through a binary 2:1 mux tree.
// Register NREGS-1 can be hardwired to zero (ZERO_TOP=1).
// Optional macro REGFILE_BYPASS_EN: forwards same-cycle write data to matching read ports.
module regfile_nr_w #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned AW       = $clog2(NREGS),
    parameter int unsigned NRD      = 2,
    parameter bit          ZERO_TOP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic                 wr_ack
);

    localparam logic [AW-1:0] TopIdx = AW'(NREGS - 1);

    logic [WIDTH-1:0]       mem_q [NREGS];
    logic [WIDTH-1:0]       mem_d [NREGS];
    logic                   wr_ack_q;
    logic                   wr_ack_d;
    logic [NREGS*WIDTH-1:0] mem_flat;

    // Next-state: update the addressed register unless it is the hardwired zero register.
    always_comb begin
        mem_d    = mem_q;
        wr_ack_d = wr_en;
        if (wr_en && !(ZERO_TOP && (wr_addr == TopIdx))) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // State: reset clears all registers and the ack immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                mem_q[i] <= '0;
            end
            wr_ack_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ack_q <= wr_ack_d;
        end
    end

    assign wr_ack = wr_ack_q;

    for (genvar r = 0; r < NREGS; r++) begin : g_flat
        assign mem_flat[r*WIDTH +: WIDTH] = mem_q[r];
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;

        assign addr = rd_addr[k*AW +: AW];

        // Level l holds NREGS>>l candidates; addr[l-1] picks between neighbouring pairs,
        // so bit 0 steers the first level and the MSB the last.
        for (genvar l = 0; l <= AW; l++) begin : g_lvl
            logic [(NREGS>>l)*WIDTH-1:0] v;
            if (l == 0) begin : g_leaf
                assign v = mem_flat;
            end else begin : g_node
                for (genvar i = 0; i < (NREGS >> l); i++) begin : g_mux
                    assign v[i*WIDTH +: WIDTH] = addr[l-1]
                        ? g_lvl[l-1].v[(2*i+1)*WIDTH +: WIDTH]
                        : g_lvl[l-1].v[(2*i)*WIDTH +: WIDTH];
                end
            end
        end

        // Output select: tree result, optional bypass, then the zero register overrides all.
        always_comb begin
            data = g_lvl[AW].v;
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (wr_addr == addr)) begin
                data = wr_data;
            end
`endif
            if (ZERO_TOP && (addr == TopIdx)) begin
                data = '0;
            end
        end

        assign rd_data[k*WIDTH +: WIDTH] = data;
    end

endmodule

// File: tb/tb_regfile_nr_w.sv
// Directed bench for regfile_nr_w: three instances (default 64x32 with 4 ports, a
// ZERO_TOP=0 twin sharing the write bus, and a 32x16 instance driven randomly vs a model).
module tb_regfile_nr_w;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Shared write bus for instances a and b
    logic         wr_en = 1'b0;
    logic [4:0]   wr_addr = '0;
    logic [63:0]  wr_data = '0;
    logic [19:0]  rd_addr_a = '0;
    logic [255:0] rd_data_a;
    logic         wr_ack_a;
    logic [9:0]   rd_addr_b = '0;
    logic [127:0] rd_data_b;
    logic         wr_ack_b;

    // Instance c (32-bit x 16)
    logic         c_wr_en = 1'b0;
    logic [3:0]   c_wr_addr = '0;
    logic [31:0]  c_wr_data = '0;
    logic [7:0]   c_rd_addr = '0;
    logic [63:0]  c_rd_data;
    logic         c_wr_ack;

    int n_total = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_nr_w #(.WIDTH(64), .NREGS(32), .NRD(4), .ZERO_TOP(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .wr_ack(wr_ack_a)
    );

    regfile_nr_w #(.WIDTH(64), .NREGS(32), .NRD(2), .ZERO_TOP(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .wr_ack(wr_ack_b)
    );

    regfile_nr_w #(.WIDTH(32), .NREGS(16), .NRD(2), .ZERO_TOP(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .rd_addr(c_rd_addr), .rd_data(c_rd_data), .wr_ack(c_wr_ack)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One write on the shared bus; returns at the following negedge with wr_en low.
    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic set_a(input int k, input logic [4:0] a);
        rd_addr_a[k*5 +: 5] = a;
    endtask

    logic [31:0] model [16];
    logic [31:0] exp_c;
    logic        prev_en;
    int          ack_cnt;

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        check_eq("rst_rd_a0", rd_data_a[63:0], 64'h0);
        check_eq("rst_ack_a", {63'h0, wr_ack_a}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset clears r5 without a clock
        wr(5'd5, 64'hDEAD_BEEF);
        set_a(0, 5'd5);
        #1;
        check_eq("r5_written", rd_data_a[63:0], 64'hDEAD_BEEF);
        check_eq("ack_after_r5", {63'h0, wr_ack_a}, 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_r5", rd_data_a[63:0], 64'h0);
        check_eq("async_rst_ack", {63'h0, wr_ack_a}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep r0..r30 back to back
        ack_cnt = 0;
        for (int i = 0; i < 31; i++) begin
            wr_en = 1'b1;
            wr_addr = 5'(i);
            wr_data = 64'(i) * 64'h0101_0101_0101_0101;
            @(negedge clk);
            if (wr_ack_a) ack_cnt++;
        end
        wr_en = 1'b0;
        check_eq("sweep_ack_cycles", 64'(ack_cnt), 64'd31);
        @(negedge clk);
        check_eq("sweep_ack_drop", {63'h0, wr_ack_a}, 64'h0);
        for (int i = 0; i < 31; i++) begin
            set_a(0, 5'(i));
            set_a(1, 5'(i));
            set_a(2, 5'(30 - i));
            set_a(3, 5'(30 - i));
            rd_addr_b[4:0] = 5'(i);
            #1;
            check_eq($sformatf("sweep_p0_r%0d", i), rd_data_a[63:0],
                     64'(i) * 64'h0101_0101_0101_0101);
            check_eq($sformatf("sweep_p1_r%0d", i), rd_data_a[127:64],
                     64'(i) * 64'h0101_0101_0101_0101);
            check_eq($sformatf("sweep_p2_r%0d", 30 - i), rd_data_a[191:128],
                     64'(30 - i) * 64'h0101_0101_0101_0101);
            check_eq($sformatf("sweep_b_r%0d", i), rd_data_b[63:0],
                     64'(i) * 64'h0101_0101_0101_0101);
        end

        // Zero register: a discards, b keeps; zero rule overrides bypass
        set_a(0, 5'd31);
        rd_addr_b[4:0] = 5'd31;
        wr_en = 1'b1;
        wr_addr = 5'd31;
        wr_data = '1;
        #1;
        check_eq("zero_byp_a", rd_data_a[63:0], 64'h0);
        check_eq("zero_byp_b", rd_data_b[63:0], BYP ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("zero_r31_a", rd_data_a[63:0], 64'h0);
        check_eq("zero_r31_b", rd_data_b[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("zero_ack_hi", {63'h0, wr_ack_a}, 64'h1);
        @(negedge clk);
        check_eq("zero_ack_lo", {63'h0, wr_ack_a}, 64'h0);

        // Same-cycle read of the write target
        wr(5'd7, 64'h11);
        set_a(0, 5'd7);
        wr_en = 1'b1;
        wr_addr = 5'd7;
        wr_data = 64'h22;
        #1;
        check_eq("same_cycle_r7", rd_data_a[63:0], BYP ? 64'h22 : 64'h11);
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("after_edge_r7", rd_data_a[63:0], 64'h22);

        // Shared address on all four ports, then distinct addresses
        wr(5'd3, 64'hA5);
        for (int k = 0; k < 4; k++) set_a(k, 5'd3);
        #1;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("shared_p%0d", k), rd_data_a[k*64 +: 64], 64'hA5);
        end
        for (int k = 0; k < 4; k++) wr(5'(k), 64'(k + 1));
        for (int k = 0; k < 4; k++) set_a(k, 5'(k));
        #1;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("distinct_p%0d", k), rd_data_a[k*64 +: 64], 64'(k + 1));
        end

        // 32x16 instance: random traffic against a reference model
        for (int i = 0; i < 16; i++) model[i] = '0;
        prev_en = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 1000; n++) begin
            c_wr_en = 1'($urandom_range(0, 1));
            c_wr_addr = 4'($urandom_range(0, 15));
            c_wr_data = $urandom;
            c_rd_addr = 8'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                exp_c = model[c_rd_addr[k*4 +: 4]];
                if (BYP && c_wr_en && (c_wr_addr == c_rd_addr[k*4 +: 4])) exp_c = c_wr_data;
                if (c_rd_addr[k*4 +: 4] == 4'd15) exp_c = '0;
                check_eq($sformatf("alt_c%0d_p%0d", n, k), 64'(c_rd_data[k*32 +: 32]),
                         64'(exp_c));
            end
            check_eq($sformatf("alt_ack%0d", n), {63'h0, c_wr_ack}, {63'h0, prev_en});
            @(posedge clk);
            if (c_wr_en && (c_wr_addr != 4'd15)) model[c_wr_addr] = c_wr_data;
            prev_en = c_wr_en;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
